// File: rtl/packet_unpacker.sv
// packet_unpacker: splits a framed byte stream (PID, ND, data, DCRC) into PID/data buffer writes
module packet_unpacker #(
   parameter int MAX_ND = 64
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_rdata,
   output logic        fifo_read,
   input  logic        pid_full,
   input  logic        data_full,
   output logic [7:0]  wbyte,
   output logic        pid_wen,
   output logic        data_wen,
   output logic [7:0]  nd_out,
   output logic [15:0] dcrc_out,
   output logic        eop,
   output logic        pid_error,
   output logic        len_error
);
   typedef enum logic [2:0] {S_PID, S_ND, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
   localparam logic [8:0] MAX_ND_W = 9'(MAX_ND);
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d, nd_q, nd_d, lo_q, lo_d;
   logic [15:0] dcrc_q, dcrc_d;
   logic        eop_q, eop_d, perr_q, perr_d, lerr_q, lerr_d;
   logic        pid_ok, too_long;
   assign wbyte     = fifo_rdata;
   assign nd_out    = nd_q;
   assign dcrc_out  = dcrc_q;
   assign eop       = eop_q;
   assign pid_error = perr_q;
   assign len_error = lerr_q;
   // pop/route decision for the head byte and next-state of the frame parser
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      nd_d      = nd_q;
      lo_d      = lo_q;
      dcrc_d    = dcrc_q;
      eop_d     = 1'b0;
      perr_d    = 1'b0;
      lerr_d    = 1'b0;
      fifo_read = 1'b0;
      pid_wen   = 1'b0;
      data_wen  = 1'b0;
      pid_ok    = fifo_rdata[7:4] == ~fifo_rdata[3:0];
      too_long  = {1'b0, fifo_rdata} > MAX_ND_W;
      case (state_q)
         S_ND: begin
            fifo_read = ~fifo_empty;
            if (fifo_read) begin
               nd_d    = fifo_rdata;
               cnt_d   = fifo_rdata;
               lerr_d  = too_long;
               state_d = too_long ? S_PID : (fifo_rdata == 8'd0) ? S_CRC_LO : S_DATA;
            end
         end
         S_DATA: begin
            fifo_read = ~fifo_empty & ~data_full;
            data_wen  = fifo_read;
            if (fifo_read) begin
               cnt_d   = cnt_q - 8'd1;
               state_d = (cnt_q == 8'd1) ? S_CRC_LO : S_DATA;
            end
         end
         S_CRC_LO: begin
            fifo_read = ~fifo_empty;
            if (fifo_read) begin
               lo_d    = fifo_rdata;
               state_d = S_CRC_HI;
            end
         end
         S_CRC_HI: begin
            fifo_read = ~fifo_empty;
            if (fifo_read) begin
               dcrc_d  = {fifo_rdata, lo_q};
               eop_d   = 1'b1;
               state_d = S_PID;
            end
         end
         default: begin
            fifo_read = ~fifo_empty & ~pid_full;
            pid_wen   = fifo_read & pid_ok;
            perr_d    = fifo_read & ~pid_ok;
            state_d   = (fifo_read & pid_ok) ? S_ND : S_PID;
         end
      endcase
   end
   // parser state and registered outputs, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= S_PID;
         cnt_q   <= '0;
         nd_q    <= '0;
         lo_q    <= '0;
         dcrc_q  <= '0;
         eop_q   <= 1'b0;
         perr_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nd_q    <= nd_d;
         lo_q    <= lo_d;
         dcrc_q  <= dcrc_d;
         eop_q   <= eop_d;
         perr_q  <= perr_d;
         lerr_q  <= lerr_d;
      end
   end
endmodule
